// File: rtl/clk_period_meter.sv
// -----------------------------------------------------------------------------
// clk_period_meter
//   Measures a slow incoming clock/PWM signal (nominally 1 MHz, 50 % duty) in
//   clk_100m cycles. Reports the last period, the high time inside that period,
//   frequency lock and loss-of-signal. Used as the receive-side sanity check
//   for divided clocks that travel across boards or pins.
//
// Ports
//   clk_100m    in   1      system clock
//   rst_n       in   1      asynchronous, active-low reset
//   sig_in      in   1      asynchronous measured signal
//   clear       in   1      synchronous clear, same effect as reset, top priority
//   period      out  CNT_W  cycles between the last two rising edges
//   high_time   out  CNT_W  cycles from rise to fall within that period
//   meas_valid  out  1      one-cycle pulse when period/high_time update
//   locked      out  1      LOCK_CNT consecutive in-tolerance periods seen
//   lost        out  1      no rising edge for TIMEOUT cycles
//   meas_cnt    out  16     number of measurements taken (wraps)
// -----------------------------------------------------------------------------
module clk_period_meter #(
    parameter int CNT_W      = 32,
    parameter int NOM_PERIOD = 100,
    parameter int TOL        = 2,
    parameter int LOCK_CNT   = 4,
    parameter int TIMEOUT    = 1000
) (
    input  logic             clk_100m,
    input  logic             rst_n,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             locked,
    output logic             lost,
    output logic [15:0]      meas_cnt
);

    localparam int RUN_W = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {IDLE, ARM, RUN, LOST} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_s1, r_s2, r_s3;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_period;
    logic [CNT_W-1:0] r_high_time;
    logic             r_meas_valid;
    logic             r_locked;
    logic             r_lost;
    logic [15:0]      r_meas_cnt;

    logic             w_rise;
    logic             w_fall;
    logic [CNT_W-1:0] w_cnt_p1;
    logic             w_in_tol;
    logic             w_measure;
    logic             w_timeout;
    logic [RUN_W-1:0] w_run_inc;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    // cnt holds "cycles since the rise minus one", so +1 is the elapsed count
    assign w_cnt_p1  = r_cnt + CNT_W'(1);
    assign w_in_tol  = (w_cnt_p1 >= CNT_W'(NOM_PERIOD - TOL)) &&
                       (w_cnt_p1 <= CNT_W'(NOM_PERIOD + TOL));
    assign w_run_inc = (r_run == RUN_W'(LOCK_CNT)) ? r_run : r_run + RUN_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_measure   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise) w_state_nxt = ARM;
            end
            ARM, RUN: begin
                // a rise arriving on the timeout cycle still counts as a measurement
                if (w_rise) begin
                    w_measure   = 1'b1;
                    w_state_nxt = RUN;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = LOST;
                end
            end
            LOST: begin
                if (w_rise) w_state_nxt = ARM;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_100m or negedge rst_n) begin
        if (!rst_n) begin
            r_s1         <= 1'b0;
            r_s2         <= 1'b0;
            r_s3         <= 1'b0;
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_hi_cnt     <= '0;
            r_run        <= '0;
            r_period     <= '0;
            r_high_time  <= '0;
            r_meas_valid <= 1'b0;
            r_locked     <= 1'b0;
            r_lost       <= 1'b0;
            r_meas_cnt   <= '0;
        end else begin
            // The synchronizer keeps running through clear so that an edge
            // coincident with clear is discarded rather than re-detected later.
            r_s1 <= sig_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
            if (clear) begin
                r_state      <= IDLE;
                r_cnt        <= '0;
                r_hi_cnt     <= '0;
                r_run        <= '0;
                r_period     <= '0;
                r_high_time  <= '0;
                r_meas_valid <= 1'b0;
                r_locked     <= 1'b0;
                r_lost       <= 1'b0;
                r_meas_cnt   <= '0;
            end else begin
                r_state      <= w_state_nxt;
                r_meas_valid <= w_measure;
                if (w_rise)
                    r_cnt <= '0;
                else if (r_cnt != CNT_W'(TIMEOUT))
                    r_cnt <= w_cnt_p1;
                if (w_fall && (r_state != IDLE))
                    r_hi_cnt <= w_cnt_p1;
                if (w_measure) begin
                    r_period    <= w_cnt_p1;
                    r_high_time <= r_hi_cnt;
                    r_meas_cnt  <= r_meas_cnt + 16'd1;
                    r_lost      <= 1'b0;
                    if (w_in_tol) begin
                        r_run    <= w_run_inc;
                        r_locked <= (w_run_inc == RUN_W'(LOCK_CNT));
                    end else begin
                        r_run    <= '0;
                        r_locked <= 1'b0;
                    end
                end
                if (w_timeout) begin
                    r_lost   <= 1'b1;
                    r_locked <= 1'b0;
                    r_run    <= '0;
                end
            end
        end
    end

    assign period     = r_period;
    assign high_time  = r_high_time;
    assign meas_valid = r_meas_valid;
    assign locked     = r_locked;
    assign lost       = r_lost;
    assign meas_cnt   = r_meas_cnt;

endmodule

// File: tb/tb_clk_period_meter.sv
// -----------------------------------------------------------------------------
// tb_clk_period_meter
//   Drives directed and randomized waveforms into clk_period_meter and compares
//   every output each cycle against a behavioural model that tracks elapsed
//   time since the last detected rise.
// -----------------------------------------------------------------------------
module tb_clk_period_meter;

    localparam int NOM     = 100;
    localparam int TOL     = 2;
    localparam int LOCK    = 4;
    localparam int TIMEOUT = 1000;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_RUN  = 2;
    localparam int M_LOST = 3;

    logic        clk_100m = 1'b0;
    logic        rst_n;
    logic        sig_in;
    logic        clear;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic        locked;
    logic        lost;
    logic [15:0] meas_cnt;

    always #5 clk_100m = ~clk_100m;

    clk_period_meter #(
        .CNT_W(32), .NOM_PERIOD(NOM), .TOL(TOL), .LOCK_CNT(LOCK), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_100m  (clk_100m),
        .rst_n     (rst_n),
        .sig_in    (sig_in),
        .clear     (clear),
        .period    (period),
        .high_time (high_time),
        .meas_valid(meas_valid),
        .locked    (locked),
        .lost      (lost),
        .meas_cnt  (meas_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    bit  h1, h2, h3;          // sig_in samples 1, 2 and 3 edges ago
    int  m_state;
    int  since;               // cycles since the last detected rise, saturating
    int  m_hi, m_run;
    int  m_period, m_high, m_mcnt;
    bit  m_mv, m_locked, m_lost;

    task automatic m_reset();
        m_state  = M_IDLE;
        since    = 0;
        m_hi     = 0;
        m_run    = 0;
        m_period = 0;
        m_high   = 0;
        m_mcnt   = 0;
        m_mv     = 0;
        m_locked = 0;
        m_lost   = 0;
    endtask

    task automatic model_step(input bit s, input bit c, input bit rn);
        bit rise, fall;
        if (!rn) begin
            h1 = 0; h2 = 0; h3 = 0;
            m_reset();
            return;
        end
        // an edge on sig_in is acted on two clock edges after it is sampled
        rise = h2 && !h3;
        fall = !h2 && h3;
        h3 = h2; h2 = h1; h1 = s;
        if (c) begin
            m_reset();
            return;
        end
        m_mv = 0;
        if (fall && m_state != M_IDLE) m_hi = since + 1;
        case (m_state)
            M_IDLE: if (rise) m_state = M_ARM;
            M_ARM, M_RUN: begin
                if (rise) begin
                    m_period = since + 1;
                    m_high   = m_hi;
                    m_mv     = 1;
                    m_mcnt   = (m_mcnt + 1) % 65536;
                    m_lost   = 0;
                    if (m_period >= NOM - TOL && m_period <= NOM + TOL) begin
                        if (m_run < LOCK) m_run++;
                        m_locked = (m_run == LOCK);
                    end else begin
                        m_run    = 0;
                        m_locked = 0;
                    end
                    m_state = M_RUN;
                end else if (since == TIMEOUT - 1) begin
                    m_state  = M_LOST;
                    m_lost   = 1;
                    m_locked = 0;
                    m_run    = 0;
                end
            end
            default: if (rise) m_state = M_ARM;
        endcase
        since = rise ? 0 : ((since < TIMEOUT) ? since + 1 : TIMEOUT);
    endtask

    // ---------------- per-cycle checking ----------------
    int k_per = 0, k_hi = 0;   // scenario constants; 0 disables
    bit k_lock = 0;
    int ph_mv = 0;             // meas_valid pulses seen in the current scenario
    int since_mv = 0;          // cycles since meas_valid was last seen

    task automatic compare_all();
        chk("period", period, m_period);
        chk("high_time", high_time, m_high);
        chk("meas_valid", meas_valid, m_mv);
        chk("locked", locked, m_locked);
        chk("lost", lost, m_lost);
        chk("meas_cnt", meas_cnt, m_mcnt);
        if (meas_valid) begin
            since_mv = 0;
            ph_mv++;
            if (k_per != 0) begin
                chk("scn_period", period, k_per);
                chk("scn_high", high_time, k_hi);
            end
            if (k_lock) begin
                chk("scn_lock", locked, ph_mv >= LOCK);
                chk("scn_mcnt", meas_cnt, ph_mv);
            end
            if (period == 105) chk("lock_drop_105", locked, 0);
        end else begin
            since_mv++;
        end
    endtask

    task automatic tick(input bit s, input bit c);
        sig_in = s;
        clear  = c;
        @(posedge clk_100m);
        model_step(s, c, rst_n);
        @(negedge clk_100m);
        compare_all();
    endtask

    task automatic wave(input int per, input int hi, input int n, input bit rc);
        for (int p = 0; p < n; p++)
            for (int i = 0; i < per; i++)
                tick(i < hi, rc && ($urandom_range(0, 299) == 0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_period"}, period, 0);
        chk({tag, "_high"}, high_time, 0);
        chk({tag, "_mv"}, meas_valid, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_lost"}, lost, 0);
        chk({tag, "_mcnt"}, meas_cnt, 0);
    endtask

    initial begin
        int  per, hi, n, r;
        bit  got_lost;
        rst_n  = 1'b0;
        sig_in = 1'b0;
        clear  = 1'b0;
        h1 = 0; h2 = 0; h3 = 0;
        m_reset();
        repeat (3) tick(0, 0);
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick(0, 0);

        // 1 MHz, 50 % duty, lock after the fourth measurement
        ph_mv = 0; k_lock = 1; k_per = 100; k_hi = 50;
        wave(100, 50, 8, 0);
        k_lock = 0; k_per = 0;

        // 30 % duty
        wave(100, 30, 1, 0);
        k_per = 100; k_hi = 30;
        wave(100, 30, 6, 0);
        k_per = 0;
        chk("duty30_locked", locked, 1);

        // off-frequency drops lock, recovery relocks
        wave(105, 50, 2, 0);
        chk("p105_unlocked", locked, 0);
        wave(100, 50, 1, 0);
        wave(100, 50, 5, 0);
        chk("p100_relock", locked, 1);

        // rise exactly on the timeout cycle wins over LOST
        wave(1000, 10, 2, 0);
        wave(100, 50, 1, 0);
        chk("rise_wins_lost", lost, 0);
        chk("rise_wins_period", period, 1000);

        // signal held low: lost exactly TIMEOUT cycles after the last rise
        wave(100, 50, 4, 0);
        got_lost = 0;
        for (int i = 0; i < 1200 && !got_lost; i++) begin
            tick(0, 0);
            if (lost) got_lost = 1;
        end
        chk("lost_seen", got_lost, 1);
        chk("lost_delay", since_mv, TIMEOUT);
        chk("lost_unlocked", locked, 0);
        wave(100, 50, 1, 0);
        chk("lost_hold", lost, 1);
        wave(100, 50, 2, 0);
        chk("lost_clear", lost, 0);

        // one cycle beyond the timeout goes LOST
        wave(1001, 10, 2, 0);
        wave(100, 50, 2, 0);

        // asynchronous reset mid-period
        wave(100, 50, 5, 0);
        for (int i = 0; i < 30; i++) tick(1, 0);
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (3) tick(1, 0);
        rst_n = 1'b1;
        ph_mv = 0;
        for (int i = 33; i < 100; i++) tick(i < 50, 0);
        chk("rst_no_early_mv", ph_mv, 0);
        wave(100, 50, 3, 0);

        // clear coincident with a detected rise
        tick(1, 0);
        tick(1, 0);
        tick(1, 1);
        chk_all_zero("clr_rise");
        for (int i = 3; i < 100; i++) tick(i < 50, 0);
        chk("clr_no_mv", meas_valid, 0);
        wave(100, 50, 3, 0);

        // randomized periods, duty cycles, clears and dropouts
        repeat (25) begin
            r = $urandom_range(0, 9);
            if (r < 5) per = 96 + $urandom_range(0, 8);
            else       per = $urandom_range(4, 250);
            hi = $urandom_range(1, per - 1);
            n  = $urandom_range(1, 4);
            wave(per, hi, n, 1);
            if (r == 9) repeat ($urandom_range(900, 1100)) tick(0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
